// File: rtl/ripple_count_capture.sv
`default_nettype none
// ============================================================================
// Module      : ripple_count_capture
// Description : Brings an asynchronous 4-bit ripple counter into the CLK
//               domain. It filters settling glitches, hands out each settled
//               count with VALID/ACK, and tallies wrap-arounds.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_count_capture #(
    parameter int STABLE_CYCLES = 2,
    parameter int OVF_WIDTH     = 8
) (
    input  logic                 CLK,
    input  logic                 CLR_N,
    input  logic                 QA,
    input  logic                 QB,
    input  logic                 QC,
    input  logic                 QD,
    input  logic                 CNT_RST,
    input  logic                 ACK,
    output logic [3:0]           COUNT,
    output logic                 VALID,
    output logic                 WRAP,
    output logic [OVF_WIDTH-1:0] OVF_CNT,
    output logic                 OVF_SAT,
    output logic                 LOST
);

    localparam logic [3:0] c_STAB_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] c_STAB_ACC = 4'(STABLE_CYCLES - 1);

    logic [4:0]           r_meta;
    logic [4:0]           r_sync;
    logic [3:0]           r_prev;
    logic [3:0]           r_stab;
    logic [3:0]           r_count;
    logic                 r_valid;
    logic                 r_wrap;
    logic [OVF_WIDTH-1:0] r_ovf;
    logic                 r_ovf_sat;
    logic                 r_lost;

    logic [3:0]           w_s;
    logic                 w_sr;
    logic                 w_same;
    logic [3:0]           w_stab_next;
    logic                 w_settled;
    logic                 w_accept;
    logic                 w_wrap;
    logic                 w_ack;
    logic                 w_overrun;
    logic [OVF_WIDTH-1:0] w_ovf_next;

    // Bit 4 carries the counter clear so it stays aligned with the count bits.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {CNT_RST, QD, QC, QB, QA};
            r_sync <= r_meta;
        end
    end

    assign w_s    = r_sync[3:0];
    assign w_sr   = r_sync[4];
    assign w_same = (w_s == r_prev);

    always_comb begin
        w_stab_next = r_stab;
        if (!w_same) begin
            w_stab_next = '0;
        end else if (r_stab != c_STAB_MAX) begin
            w_stab_next = r_stab + 4'd1;
        end
    end

    generate
        if (STABLE_CYCLES == 1) begin : g_stab_single
            assign w_settled = 1'b1;
        end else begin : g_stab_multi
            // Hitting STABLE_CYCLES-1 happens once per run of identical samples.
            assign w_settled = (w_stab_next == c_STAB_ACC);
        end
    endgenerate

    assign w_accept  = w_settled && (w_s != r_count);
    assign w_wrap    = w_accept && (w_s < r_count) && !w_sr;
    assign w_ack     = ACK && r_valid;
    assign w_overrun = w_accept && r_valid && !ACK;

    always_comb begin
        w_ovf_next = r_ovf;
        if (w_wrap && !(&r_ovf)) begin
            w_ovf_next = r_ovf + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_prev    <= '0;
            r_stab    <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_wrap    <= 1'b0;
            r_ovf     <= '0;
            r_ovf_sat <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            r_prev    <= w_s;
            r_stab    <= w_stab_next;
            r_wrap    <= w_wrap;
            r_ovf     <= w_ovf_next;
            r_ovf_sat <= r_ovf_sat | (&w_ovf_next);

            if (w_accept) begin
                r_count <= w_s;
                r_valid <= 1'b1;
            end else if (w_ack) begin
                r_valid <= 1'b0;
            end

            if (w_overrun) begin
                r_lost <= 1'b1;
            end else if (w_ack) begin
                r_lost <= 1'b0;
            end
        end
    end

    assign COUNT   = r_count;
    assign VALID   = r_valid;
    assign WRAP    = r_wrap;
    assign OVF_CNT = r_ovf;
    assign OVF_SAT = r_ovf_sat;
    assign LOST    = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_count_capture
// Description : Directed self-checking bench for ripple_count_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_count_capture;

    localparam int STABLE_CYCLES = 2;
    localparam int OVF_WIDTH     = 8;

    logic                 CLK;
    logic                 CLR_N;
    logic                 QA, QB, QC, QD;
    logic                 CNT_RST;
    logic                 ACK;
    logic [3:0]           COUNT;
    logic                 VALID;
    logic                 WRAP;
    logic [OVF_WIDTH-1:0] OVF_CNT;
    logic                 OVF_SAT;
    logic                 LOST;

    int n_checks = 0;
    int n_pass   = 0;

    ripple_count_capture #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .OVF_WIDTH    (OVF_WIDTH)
    ) u_dut (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .QA     (QA),
        .QB     (QB),
        .QC     (QC),
        .QD     (QD),
        .CNT_RST(CNT_RST),
        .ACK    (ACK),
        .COUNT  (COUNT),
        .VALID  (VALID),
        .WRAP   (WRAP),
        .OVF_CNT(OVF_CNT),
        .OVF_SAT(OVF_SAT),
        .LOST   (LOST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_q(input logic [3:0] v);
        {QD, QC, QB, QA} = v;
    endtask

    int n_valid8;
    int n_wrap;
    int n_vpulse;

    initial begin
        CLR_N   = 1'b0;
        CNT_RST = 1'b0;
        ACK     = 1'b0;
        set_q(4'h0);
        step(3);
        check("rst_count", 32'(COUNT), 32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_ovf",   32'(OVF_CNT), 32'h0);
        CLR_N = 1'b1;

        // Idle: zero input must never produce an accept.
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("idle_valid", 32'(VALID), 32'h0);
            check("idle_count", 32'(COUNT), 32'h0);
            check("idle_wrap",  32'(WRAP), 32'h0);
            check("idle_ovf",   32'(OVF_CNT), 32'h0);
        end

        // Settled step 0000 -> 0011 with ACK tied high: VALID after 2+2 cycles.
        ACK = 1'b1;
        set_q(4'h3);
        n_vpulse = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (VALID) n_vpulse++;
        end
        check("step_early_valid", 32'(n_vpulse), 32'd0);
        step(1);
        check("step_valid", 32'(VALID), 32'h1);
        check("step_count", 32'(COUNT), 32'h3);
        step(1);
        check("step_valid_clr", 32'(VALID), 32'h0);

        // Ripple glitch 0111 -> 0110 -> 0100 -> 0000 -> 1000.
        set_q(4'h7);
        step(6);
        check("glitch_pre_count", 32'(COUNT), 32'h7);
        n_valid8 = 0;
        n_vpulse = 0;
        n_wrap   = 0;
        set_q(4'h6); step(1);
        if (VALID) n_vpulse++;
        set_q(4'h4); step(1);
        if (VALID) n_vpulse++;
        set_q(4'h0); step(1);
        if (VALID) n_vpulse++;
        set_q(4'h8);
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (VALID) begin
                n_vpulse++;
                if (COUNT == 4'h8) n_valid8++;
            end
            if (WRAP) n_wrap++;
        end
        check("glitch_vpulses", 32'(n_vpulse), 32'd1);
        check("glitch_valid8",  32'(n_valid8), 32'd1);
        check("glitch_wrap",    32'(n_wrap), 32'd0);
        check("glitch_count",   32'(COUNT), 32'h8);

        // Clear vs wrap: decrease 1010 -> 0000 while CNT_RST is high.
        set_q(4'hA);
        step(6);
        check("clr_pre_count", 32'(COUNT), 32'hA);
        ACK     = 1'b0;
        CNT_RST = 1'b1;
        set_q(4'h0);
        n_wrap = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (WRAP) n_wrap++;
        end
        check("clr_count", 32'(COUNT), 32'h0);
        check("clr_valid", 32'(VALID), 32'h1);
        step(2);
        if (WRAP) n_wrap++;
        check("clr_wrap", 32'(n_wrap), 32'd0);
        check("clr_ovf",  32'(OVF_CNT), 32'h0);
        CNT_RST = 1'b0;
        ACK     = 1'b1;
        step(4);
        check("clr_ack_valid", 32'(VALID), 32'h0);

        // 256 wraps 1111 -> 0000: tally saturates at 255.
        n_wrap = 0;
        for (int k = 0; k < 256; k++) begin
            set_q(4'hF);
            step(5);
            set_q(4'h0);
            for (int i = 0; i < 5; i++) begin
                step(1);
                if (WRAP) n_wrap++;
            end
            if (k == 0)   check("wrap_ovf_1",   32'(OVF_CNT), 32'd1);
            if (k == 253) check("wrap_ovf_254", 32'(OVF_CNT), 32'd254);
            if (k == 253) check("wrap_sat_254", 32'(OVF_SAT), 32'd0);
            if (k == 254) check("wrap_ovf_255", 32'(OVF_CNT), 32'd255);
            if (k == 254) check("wrap_sat_255", 32'(OVF_SAT), 32'd1);
        end
        check("wrap_pulses",  32'(n_wrap), 32'd256);
        check("wrap_ovf_end", 32'(OVF_CNT), 32'd255);
        check("wrap_sat_end", 32'(OVF_SAT), 32'd1);

        // Overrun: two settled values without ACK.
        ACK = 1'b0;
        set_q(4'h1);
        step(4);
        check("ovr_first_count", 32'(COUNT), 32'h1);
        check("ovr_first_lost",  32'(LOST), 32'h0);
        set_q(4'h2);
        step(4);
        check("ovr_count", 32'(COUNT), 32'h2);
        check("ovr_valid", 32'(VALID), 32'h1);
        check("ovr_lost",  32'(LOST), 32'h1);
        ACK = 1'b1;
        step(1);
        ACK = 1'b0;
        check("ovr_ack_valid", 32'(VALID), 32'h0);
        check("ovr_ack_lost",  32'(LOST), 32'h0);

        // Asynchronous reset while VALID is pending.
        set_q(4'h3);
        step(4);
        check("mid_pre_valid", 32'(VALID), 32'h1);
        #2 CLR_N = 1'b0;
        #1;
        check("mid_count", 32'(COUNT), 32'h0);
        check("mid_valid", 32'(VALID), 32'h0);
        check("mid_wrap",  32'(WRAP), 32'h0);
        check("mid_ovf",   32'(OVF_CNT), 32'h0);
        check("mid_sat",   32'(OVF_SAT), 32'h0);
        check("mid_lost",  32'(LOST), 32'h0);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
